lmem_arbiter: RTL and testbench



---
 rtl/lmem_pkg.sv | 27 ++
 rtl/lmem_arbiter_if.sv | 50 +++++
 rtl/lmem_arbiter_rr_pick.sv | 40 ++++
 rtl/lmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_lmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lmem_pkg.sv
// Shared definitions for the layer-memory arbiter.
//   - Default widths for address, data and layer select.
//   - Layer-select codes driven onto csel.
//   - FSM state type of the arbiter.
//   - idx_width(): width of a requester index. It is never less than 1 bit.
package lmem_pkg;

    localparam int NREQ_DEFAULT     = 2;
    localparam int AW_DEFAULT       = 12;
    localparam int DW_DEFAULT       = 20;
    localparam int SW_DEFAULT       = 3;
    localparam int LOCK_MAX_DEFAULT = 16;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic {
        FREE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lmem_arbiter_if.sv
// Bundle of all signals between the CNN engines, the arbiter and the
// layer memory.
//   Engine side : req, lock, we, sel, addr, wdata  (packed per requester)
//                 gnt, rvalid, rdata, busy
//   Memory side : cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, cdata_rd
// Modports:
//   slave  - the arbiter's view.
//   master - the environment's view (engines plus memory).
//
// Handshake: req[i] acts as "valid" and gnt[i] acts as "ready". An access
// transfers in the cycle where both are 1. While req[i] is 1 and gnt[i] is
// 0, the requester must hold req[i] and keep lock/we/sel/addr/wdata[i]
// stable. rvalid[i] is a one-cycle pulse with no back-pressure.
interface lmem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 12,
    parameter int DW   = 20,
    parameter int SW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*SW-1:0] sel;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               busy;

    logic               cwr;
    logic               crd;
    logic [AW-1:0]      caddr_wr;
    logic [AW-1:0]      caddr_rd;
    logic [DW-1:0]      cdata_wr;
    logic [DW-1:0]      cdata_rd;
    logic [SW-1:0]      csel;

    modport slave (
        input  req, lock, we, sel, addr, wdata, cdata_rd,
        output gnt, rvalid, rdata, busy,
               cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
    );

    modport master (
        output req, lock, we, sel, addr, wdata, cdata_rd,
        input  gnt, rvalid, rdata, busy,
               cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
    );
endinterface

// File: rtl/lmem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     in  NREQ  requesting lanes
//   last    in  IW    index of the most recent grant
//   win     out NREQ  one-hot winner (all zero when nothing requests)
//   win_idx out IW    index of the winner
//   any     out 1     a winner exists
// The scan starts at last+1 and wraps, so it finds the first requester
// strictly after last.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    int            idx;
    logic [IW-1:0] idx_n;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_n   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last) + k) % NREQ;
            idx_n = IW'(idx);
            if (!any && req[idx_n]) begin
                any        = 1'b1;
                win[idx_n] = 1'b1;
                win_idx    = idx_n;
            end
        end
    end

endmodule

// File: rtl/lmem_arbiter.sv
// Round-robin arbiter that shares the single layer-memory port among
// NREQ CNN engines.
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   bus       slave modport of lmem_arbiter_if (engine and memory signals)
//   dbg_state out  current FSM state (FREE/OWNED)
// Behaviour:
//   - Grant (gnt) is combinational.
//   - Memory strobes, address, data and csel are registered.
//   - Read data returns on rvalid two cycles after the grant, tagged with
//     the index of the requester that issued the read.
//   - A locked requester keeps ownership until one of these happens:
//       * it drops lock,
//       * it drops req,
//       * it has taken LOCK_MAX accesses.
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int NREQ     = NREQ_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int SW       = SW_DEFAULT,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    lmem_arbiter_if.slave  bus,
    output arb_state_t     dbg_state
);

    localparam int            IW        = idx_width(NREQ);
    localparam int            CW        = $clog2(LOCK_MAX) + 1;
    localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
    // lcnt counts the accesses already taken in the burst. A grant made
    // while lcnt == LOCK_MAX-1 is therefore the LOCK_MAX-th grant, and it
    // ends the burst.
    localparam logic [CW-1:0] LCNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_t      state, state_next;
    logic [IW-1:0]   last, last_next;
    logic [IW-1:0]   owner, owner_next;
    logic [CW-1:0]   lcnt, lcnt_next;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   win_idx;
    logic            granted;

    logic            f_we;
    logic [AW-1:0]   f_addr;
    logic [DW-1:0]   f_wdata;
    logic [SW-1:0]   f_sel;

    logic            mem_wr, mem_rd;
    logic [AW-1:0]   mem_addr_wr, mem_addr_rd;
    logic [DW-1:0]   mem_data_wr;
    logic [SW-1:0]   mem_sel;

    logic            tag_vld;
    logic [IW-1:0]   tag_idx;
    logic [NREQ-1:0] rvalid_r;
    logic [DW-1:0]   rdata_r;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (bus.req),
        .last    (last),
        .win     (pick_onehot),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FREE;
            last  <= LAST_RST;
            owner <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            owner <= owner_next;
            lcnt  <= lcnt_next;
        end
    end

    // Next-state and grant logic.
    always_comb begin
        state_next = state;
        last_next  = last;
        owner_next = owner;
        lcnt_next  = lcnt;
        gnt        = '0;
        win_idx    = pick_idx;
        granted    = 1'b0;
        unique case (state)
            FREE: begin
                if (pick_any) begin
                    granted   = 1'b1;
                    gnt       = pick_onehot;
                    last_next = pick_idx;
                    // With LOCK_MAX of 1, a burst is a single access and
                    // never needs to hold ownership.
                    if (bus.lock[pick_idx] && LOCK_MAX > 1) begin
                        state_next = OWNED;
                        owner_next = pick_idx;
                        lcnt_next  = CW'(1);
                    end
                end
            end
            OWNED: begin
                win_idx = owner;
                if (bus.req[owner]) begin
                    granted    = 1'b1;
                    gnt[owner] = 1'b1;
                    last_next  = owner;
                    if (!bus.lock[owner] || lcnt == LCNT_LAST) begin
                        state_next = FREE;
                    end else begin
                        lcnt_next = lcnt + 1'b1;
                    end
                end else begin
                    state_next = FREE;
                end
            end
            default: state_next = FREE;
        endcase
    end

    // Select the winner's request fields.
    always_comb begin
        f_we    = 1'b0;
        f_addr  = '0;
        f_wdata = '0;
        f_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                f_we    = bus.we[i];
                f_addr  = bus.addr[i*AW +: AW];
                f_wdata = bus.wdata[i*DW +: DW];
                f_sel   = bus.sel[i*SW +: SW];
            end
        end
    end

    // Memory-port registers. Address, data and select hold their values
    // while no access is granted. Only the strobes drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr_wr <= '0;
            mem_addr_rd <= '0;
            mem_data_wr <= '0;
            mem_sel     <= SW'(CSEL_NONE);
        end else if (granted) begin
            if (f_we) begin
                mem_wr      <= 1'b1;
                mem_rd      <= 1'b0;
                mem_addr_wr <= f_addr;
                mem_data_wr <= f_wdata;
                mem_sel     <= f_sel;
            end else begin
                mem_wr      <= 1'b0;
                mem_rd      <= 1'b1;
                mem_addr_rd <= f_addr;
                mem_sel     <= f_sel;
            end
        end else begin
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;
        end
    end

    // Two-stage read-return pipe.
    //   Stage 1 (tag_vld/tag_idx) is live while crd is on the bus.
    //   Stage 2 (rvalid_r/rdata_r) captures cdata_rd at the end of that
    //   cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld  <= 1'b0;
            tag_idx  <= '0;
            rvalid_r <= '0;
            rdata_r  <= '0;
        end else begin
            tag_vld  <= granted && !f_we;
            tag_idx  <= win_idx;
            rvalid_r <= '0;
            if (tag_vld) begin
                rvalid_r[tag_idx] <= 1'b1;
                rdata_r           <= bus.cdata_rd;
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_r;
    assign bus.rdata    = rdata_r;
    assign bus.busy     = (state == OWNED) || tag_vld || (|rvalid_r);
    assign bus.cwr      = mem_wr;
    assign bus.crd      = mem_rd;
    assign bus.caddr_wr = mem_addr_wr;
    assign bus.caddr_rd = mem_addr_rd;
    assign bus.cdata_wr = mem_data_wr;
    assign bus.csel     = mem_sel;
    assign dbg_state    = state;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter.
//   - A layer-memory model returns data combinationally on caddr_rd.
//   - A shadow array tracks the content that each read should return.
//   - Granted reads push {requester, data} onto exp_q.
//   - A negedge monitor pops exp_q on every rvalid and compares.
module tb_lmem_arbiter;
    import lmem_pkg::*;

    localparam int NREQ     = 2;
    localparam int AW       = 12;
    localparam int DW       = 20;
    localparam int SW       = 3;
    localparam int LOCK_MAX = 16;
    localparam int IW       = 1;
    localparam int EW       = IW + DW;
    localparam int DEPTH    = 1 << AW;

    logic       clk = 1'b0;
    logic       reset;
    arb_state_t dbg_state;

    lmem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) bus ();

    lmem_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Memory model.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 12'h041) return 20'h0ABCD;
        return {8'hA5, a};
    endfunction

    logic [DW-1:0] mem [0:DEPTH-1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(AW'(i));
        end else if (bus.cwr) begin
            mem[bus.caddr_wr] <= bus.cdata_wr;
        end
    end

    assign bus.cdata_rd = mem[bus.caddr_rd];

    // Scoreboard state.
    int            n_checks = 0;
    int            n_errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] shadow [0:DEPTH-1];

    logic [SW-1:0] f_sel   [NREQ];
    logic [AW-1:0] f_addr  [NREQ];
    logic [DW-1:0] f_wdata [NREQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic init_shadow();
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(AW'(i));
    endtask

    // Drivers.
    // One cycle:
    //   1. Drive req/lock/we and the staged fields just after the posedge.
    //   2. Sample gnt at the negedge.
    //   3. Update the scoreboard for the granted access.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                        input logic [NREQ-1:0] w, output logic [NREQ-1:0] g);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.lock = l;
        bus.we   = w;
        for (int i = 0; i < NREQ; i++) begin
            bus.sel[i*SW +: SW]   = f_sel[i];
            bus.addr[i*AW +: AW]  = f_addr[i];
            bus.wdata[i*DW +: DW] = f_wdata[i];
        end
        @(negedge clk);
        g = bus.gnt;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                if (w[i]) shadow[f_addr[i]] = f_wdata[i];
                else      exp_q.push_back({IW'(i), shadow[f_addr[i]]});
            end
        end
    endtask

    task automatic idle(input int n);
        logic [NREQ-1:0] g;
        for (int k = 0; k < n; k++) step('0, '0, '0, g);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_gnt"},      32'(bus.gnt),      0);
        check_eq({pfx, "_rvalid"},   32'(bus.rvalid),   0);
        check_eq({pfx, "_busy"},     32'(bus.busy),     0);
        check_eq({pfx, "_cwr"},      32'(bus.cwr),      0);
        check_eq({pfx, "_crd"},      32'(bus.crd),      0);
        check_eq({pfx, "_caddr_wr"}, 32'(bus.caddr_wr), 0);
        check_eq({pfx, "_caddr_rd"}, 32'(bus.caddr_rd), 0);
        check_eq({pfx, "_cdata_wr"}, 32'(bus.cdata_wr), 0);
        check_eq({pfx, "_rdata"},    32'(bus.rdata),    0);
        check_eq({pfx, "_csel"},     32'(bus.csel),     0);
        check_eq({pfx, "_state"},    32'(dbg_state),    32'(FREE));
    endtask

    // Read-return monitor.
    logic [EW-1:0]   mon_e;
    logic [NREQ-1:0] mon_oh;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            check_eq("strobe_excl", 32'(bus.cwr & bus.crd), 0);
            if (bus.rvalid !== '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("rvalid_spurious", 32'(bus.rvalid), 0);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e[EW-1 -: IW]] = 1'b1;
                    check_eq("rd_owner", 32'(bus.rvalid), 32'(mon_oh));
                    check_eq("rd_data",  32'(bus.rdata),  32'(mon_e[DW-1:0]));
                end
            end
        end
    end

    // Main sequence.
    initial begin
        logic [NREQ-1:0] g;
        logic            req1_pend;
        int              n0;

        reset     = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.sel   = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            f_sel[i]   = CSEL_L0;
            f_addr[i]  = '0;
            f_wdata[i] = '0;
        end
        init_shadow();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contention fairness: the first grant goes to requester 0
        // because last starts at NREQ-1.
        f_addr[0] = 12'h010;
        f_addr[1] = 12'h020;
        for (int k = 0; k < 8; k++) begin
            step(2'b11, 2'b00, 2'b00, g);
            check_eq("fair_gnt", 32'(g), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle(3);

        // Single read.
        f_addr[0] = 12'h041;
        f_sel[0]  = CSEL_L0;
        step(2'b01, 2'b00, 2'b00, g);
        check_eq("rd1_gnt", 32'(g), 32'h1);
        step(2'b00, 2'b00, 2'b00, g);
        check_eq("rd1_crd",      32'(bus.crd),      1);
        check_eq("rd1_cwr",      32'(bus.cwr),      0);
        check_eq("rd1_caddr_rd", 32'(bus.caddr_rd), 32'h041);
        check_eq("rd1_csel",     32'(bus.csel),     32'(CSEL_L0));
        check_eq("rd1_busy",     32'(bus.busy),     1);
        step(2'b00, 2'b00, 2'b00, g);
        check_eq("rd1_rvalid", 32'(bus.rvalid), 32'h1);
        check_eq("rd1_rdata",  32'(bus.rdata),  32'h0ABCD);
        step(2'b00, 2'b00, 2'b00, g);
        check_eq("rd1_rvalid_end", 32'(bus.rvalid), 0);
        check_eq("rd1_busy_end",   32'(bus.busy),   0);

        // Write, then read the same address in the next cycle.
        f_addr[0]  = 12'h077;
        f_wdata[0] = 20'h54321;
        f_sel[0]   = CSEL_L1;
        step(2'b01, 2'b00, 2'b01, g);
        check_eq("wr_gnt", 32'(g), 32'h1);
        step(2'b01, 2'b00, 2'b00, g);
        check_eq("raw_gnt",      32'(g),            32'h1);
        check_eq("wr_cwr",       32'(bus.cwr),      1);
        check_eq("wr_caddr_wr",  32'(bus.caddr_wr), 32'h077);
        check_eq("wr_cdata_wr",  32'(bus.cdata_wr), 32'h54321);
        idle(3);

        // Pool-style burst: requester 1 issues 4 locked reads and then an
        // unlocked write. Requester 0 requests throughout.
        f_addr[0]  = 12'h040;
        f_sel[0]   = CSEL_L0;
        f_addr[1]  = 12'h030;
        f_sel[1]   = CSEL_L1;
        step(2'b10, 2'b10, 2'b00, g);
        check_eq("burst_gnt0", 32'(g), 32'h2);
        for (int k = 1; k < 4; k++) begin
            step(2'b11, 2'b10, 2'b00, g);
            check_eq("burst_gnt",   32'(g),         32'h2);
            check_eq("burst_state", 32'(dbg_state), 32'(OWNED));
            check_eq("burst_busy",  32'(bus.busy),  1);
        end
        f_addr[1]  = 12'h005;
        f_wdata[1] = 20'h00123;
        f_sel[1]   = CSEL_L1;
        step(2'b11, 2'b00, 2'b10, g);
        check_eq("burst_wr_gnt", 32'(g), 32'h2);
        step(2'b01, 2'b00, 2'b00, g);
        check_eq("burst_next_gnt", 32'(g),            32'h1);
        check_eq("burst_cwr",      32'(bus.cwr),      1);
        check_eq("burst_crd",      32'(bus.crd),      0);
        check_eq("burst_caddr_wr", 32'(bus.caddr_wr), 32'h005);
        check_eq("burst_cdata_wr", 32'(bus.cdata_wr), 32'h00123);
        check_eq("burst_csel",     32'(bus.csel),     32'(CSEL_L1));
        idle(2);
        step(2'b10, 2'b00, 2'b00, g);
        check_eq("burst_rb_gnt", 32'(g), 32'h2);
        idle(3);

        // Forced release: requester 0 keeps lock for 20 accesses. The
        // grant after its 16th one goes to requester 1.
        f_addr[1] = 12'h041;
        f_sel[1]  = CSEL_L0;
        req1_pend = 1'b0;
        n0        = 0;
        for (int c = 0; c < 21; c++) begin
            f_addr[0] = AW'(12'h100 + n0);
            step({req1_pend, 1'b1}, 2'b01, 2'b00, g);
            check_eq("lock_gnt", 32'(g), (c == LOCK_MAX) ? 32'h2 : 32'h1);
            if (g[0]) n0++;
            if (c == 0) req1_pend = 1'b1;
            if (g[1])   req1_pend = 1'b0;
        end
        check_eq("lock_n0", 32'(n0), 32'd20);
        idle(4);
        check_eq("lock_busy_end", 32'(bus.busy), 0);

        // Reset in the cycle after a read grant.
        f_addr[0] = 12'h041;
        step(2'b01, 2'b00, 2'b00, g);
        check_eq("rst_rd_gnt", 32'(g), 32'h1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.we   = '0;
        @(negedge clk);
        check_all_zero("midrst");
        exp_q.delete();
        init_shadow();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(2'b00, 2'b00, 2'b00, g);
            check_eq("post_rst_rvalid", 32'(bus.rvalid), 0);
        end

        check_eq("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
